// File: rtl/pop_pkg.sv
// rtl/pop_pkg.sv - shared FSM state type and video counter widths for the pop controller
package pop_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POPPED
  } pop_state_t;

endpackage

// File: rtl/pop_if.sv
// rtl/pop_if.sv - button/video-timing/pop bundle with source and controller modports
interface pop_if #(
  parameter int COUNT_W = 16
) ();
  import pop_pkg::*;

  logic                btn;
  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                pop;
  logic                pop_pulse;
  logic [COUNT_W-1:0]  pop_count;

  modport master (output btn, hcount, vcount, input pop, pop_pulse, pop_count);
  modport slave  (input btn, hcount, vcount, output pop, pop_pulse, pop_count);

endinterface

// File: rtl/debouncer.sv
// rtl/debouncer.sv - 2-flop synchronizer plus stable-level debounce with registered rise strobe
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 371250
) (
  input  logic pixel_clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic clean_out,
  output logic rise_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  assign clean_out = stable;

  // The level flips on the edge that completes DEBOUNCE_CYCLES mismatching samples.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      cnt      <= '0;
      rise_out <= 1'b0;
    end else begin
      sync1    <= btn_in;
      sync2    <= sync1;
      rise_out <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable   <= sync2;
          cnt      <= '0;
          rise_out <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pop_controller.sv
// rtl/pop_controller.sv - debounced pop button driving a frame-aligned pop hold FSM and saturating press count
module pop_controller
  import pop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 371250,
  parameter int POP_FRAMES      = 6,
  parameter int COUNT_W         = 16
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic                btn_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic                pop_out,
  output logic                pop_pulse_out,
  output logic [COUNT_W-1:0]  pop_count_out
);

  localparam int HOLD_W = $clog2(POP_FRAMES + 1);

  logic              btn_level;
  logic              btn_rise;
  logic              press;
  logic              frame_start;
  logic              retrig;
  logic [HOLD_W-1:0] hold;
  pop_state_t        state;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .pixel_clk_in(pixel_clk_in),
    .rst_in      (rst_in),
    .btn_in      (btn_in),
    .clean_out   (btn_level),
    .rise_out    (btn_rise)
  );

  assign press       = btn_rise & btn_level;
  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= ST_IDLE;
      pop_out       <= 1'b0;
      pop_pulse_out <= 1'b0;
      pop_count_out <= '0;
      hold          <= '0;
      retrig        <= 1'b0;
    end else begin
      pop_pulse_out <= press;
      if (pop_pulse_out && (pop_count_out != '1)) begin
        pop_count_out <= pop_count_out + COUNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (press) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (frame_start) begin
            state   <= ST_POPPED;
            hold    <= HOLD_W'(POP_FRAMES);
            pop_out <= 1'b1;
            retrig  <= 1'b0;
          end
        end
        ST_POPPED: begin
          if (frame_start) begin
            // A press landing on this frame_start counts toward the next boundary.
            if (retrig) begin
              hold   <= HOLD_W'(POP_FRAMES);
              retrig <= press;
            end else if (hold == HOLD_W'(1)) begin
              hold    <= '0;
              pop_out <= 1'b0;
              retrig  <= 1'b0;
              state   <= press ? ST_ARMED : ST_IDLE;
            end else begin
              hold   <= hold - HOLD_W'(1);
              retrig <= press;
            end
          end else if (press) begin
            retrig <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pop_controller.sv
// tb/tb_pop_controller.sv - scoreboard bench: directed presses, retrigger, frame-aligned press, reset, saturation
module tb_pop_controller;
  import pop_pkg::*;

  typedef struct {
    int cyc;
    int c16;
    int c2;
  } pulse_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_press = 0;

  pulse_exp_t pulse_q[$];
  int         rise_q[$];
  int         fall_q[$];

  pop_if #(.COUNT_W(16)) bus1 ();
  pop_if #(.COUNT_W(2))  bus2 ();

  assign bus2.btn    = bus1.btn;
  assign bus2.hcount = bus1.hcount;
  assign bus2.vcount = bus1.vcount;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pop_controller #(.DEBOUNCE_CYCLES(4), .POP_FRAMES(3), .COUNT_W(16)) dut16 (
    .pixel_clk_in (clk),
    .rst_in       (rst_n),
    .btn_in       (bus1.btn),
    .hcount_in    (bus1.hcount),
    .vcount_in    (bus1.vcount),
    .pop_out      (bus1.pop),
    .pop_pulse_out(bus1.pop_pulse),
    .pop_count_out(bus1.pop_count)
  );

  pop_controller #(.DEBOUNCE_CYCLES(4), .POP_FRAMES(3), .COUNT_W(2)) dut2 (
    .pixel_clk_in (clk),
    .rst_in       (rst_n),
    .btn_in       (bus2.btn),
    .hcount_in    (bus2.hcount),
    .vcount_in    (bus2.vcount),
    .pop_out      (bus2.pop),
    .pop_pulse_out(bus2.pop_pulse),
    .pop_count_out(bus2.pop_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: got an event, expected none", name, cyc);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic int sat2(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // Edge e sees h = e%8, v = (e/8)%4, so frame_start falls on every edge that is a multiple of 32.
  always @(negedge clk) begin
    bus1.hcount = HCOUNT_W'((cyc + 1) % 8);
    bus1.vcount = VCOUNT_W'(((cyc + 1) / 8) % 4);
  end

  // Button rises at negedge k: pulse visible at negedge k+7, count one cycle later.
  task automatic press(input int k, input int hold_cycles);
    wait_to(k);
    bus1.btn = 1'b1;
    n_press++;
    pulse_q.push_back('{cyc: k + 7, c16: n_press, c2: sat2(n_press)});
    wait_to(k + hold_cycles);
    bus1.btn = 1'b0;
  endtask

  logic       prev_pop = 1'b0;
  logic       cnt_pend = 1'b0;
  int         exp_c16;
  int         exp_c2;
  pulse_exp_t pe;

  always @(negedge clk) begin
    if (cnt_pend) begin
      chk("count16", int'(bus1.pop_count), exp_c16);
      chk("count2", int'(bus2.pop_count), exp_c2);
      cnt_pend = 1'b0;
    end
    if (bus1.pop_pulse || bus2.pop_pulse) begin
      chk("pulse_match", int'(bus2.pop_pulse), int'(bus1.pop_pulse));
      if (pulse_q.size() == 0) begin
        fail_now("unexpected_pulse");
      end else begin
        pe = pulse_q.pop_front();
        chk("pulse_cycle", cyc, pe.cyc);
        exp_c16  = pe.c16;
        exp_c2   = pe.c2;
        cnt_pend = 1'b1;
      end
    end
    if (bus1.pop != prev_pop) begin
      chk("pop_match", int'(bus2.pop), int'(bus1.pop));
      if (bus1.pop) begin
        if (rise_q.size() == 0) fail_now("unexpected_pop_rise");
        else chk("pop_rise_cycle", cyc, rise_q.pop_front());
      end else begin
        if (fall_q.size() == 0) fail_now("unexpected_pop_fall");
        else chk("pop_fall_cycle", cyc, fall_q.pop_front());
      end
    end
    prev_pop = bus1.pop;
  end

  initial begin
    rst_n       = 1'b0;
    bus1.btn    = 1'b0;
    bus1.hcount = '0;
    bus1.vcount = '0;
    @(negedge clk);
    chk("reset_pop", int'(bus1.pop), 0);
    chk("reset_pulse", int'(bus1.pop_pulse), 0);
    chk("reset_count16", int'(bus1.pop_count), 0);
    chk("reset_count2", int'(bus2.pop_count), 0);
    wait_to(3);
    rst_n = 1'b1;

    // 3-cycle glitch: never debounced
    wait_to(10);
    bus1.btn = 1'b1;
    wait_to(13);
    bus1.btn = 1'b0;
    wait_to(39);
    chk("glitch_count", int'(bus1.pop_count), 0);
    chk("glitch_pop", int'(bus1.pop), 0);

    // single held press, then a retrigger press inside POPPED
    rise_q.push_back(64);
    press(40, 20);
    fall_q.push_back(224);
    press(100, 20);

    // press accepted exactly on frame_start from IDLE
    rise_q.push_back(288);
    fall_q.push_back(384);
    press(249, 20);

    // reset mid-POPPED with the button still held through release
    wait_to(400);
    bus1.btn = 1'b1;
    n_press++;
    pulse_q.push_back('{cyc: 407, c16: n_press, c2: sat2(n_press)});
    rise_q.push_back(416);
    wait_to(430);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pop", int'(bus1.pop), 0);
    chk("async_rst_pulse", int'(bus1.pop_pulse), 0);
    chk("async_rst_count16", int'(bus1.pop_count), 0);
    chk("async_rst_count2", int'(bus2.pop_count), 0);
    n_press = 0;
    fall_q.push_back(431);
    @(negedge clk);
    rst_n = 1'b1;
    n_press++;
    pulse_q.push_back('{cyc: 438, c16: n_press, c2: sat2(n_press)});
    rise_q.push_back(448);
    fall_q.push_back(544);
    wait_to(460);
    bus1.btn = 1'b0;

    // four more presses: saturation on the narrow counter, chained retriggers
    rise_q.push_back(576);
    fall_q.push_back(800);
    press(560, 15);
    press(600, 15);
    press(640, 15);
    press(680, 15);

    wait_to(830);
    chk("final_count16", int'(bus1.pop_count), 5);
    chk("final_count2", int'(bus2.pop_count), 3);
    chk("final_pop", int'(bus1.pop), 0);
    chk("pulse_q_drained", pulse_q.size(), 0);
    chk("rise_q_drained", rise_q.size(), 0);
    chk("fall_q_drained", fall_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
